// File: rtl/sha512_msg_pad.sv
// SHA-512 message feeder: packs 64-bit words into 1024-bit blocks, applies FIPS 180-4 padding, sequences the core.
// Latency: the last word at index k gives o_core_start 16-k cycles later (one-block finish).
// Backpressure: o_ready is high only while filling; PAD, START, WAIT and OUT all stall the input stream.
module sha512_msg_pad #(
   parameter logic [511:0] P_IV   = 512'h6a09e667f3bcc908_bb67ae8584caa73b_3c6ef372fe94f82b_a54ff53a5f1d36f1_510e527fade682d1_9b05688c2b3e6c1f_1f83d9abfb41bd6b_5be0cd19137e2179,
   parameter int           P_LENW = 128
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [63:0]   i_data,
   input  logic          i_valid,
   input  logic          i_last,
   input  logic [3:0]    i_nbytes,
   output logic          o_ready,
   output logic          o_core_start,
   output logic [1023:0] o_core_data,
   output logic [511:0]  o_core_vin,
   input  logic [511:0]  i_core_vout,
   input  logic          i_core_done,
   output logic [511:0]  o_hash,
   output logic          o_hash_valid
);

   localparam logic [2:0] S_FILL  = 3'd0;
   localparam logic [2:0] S_PAD   = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   logic [2:0]         r_state;
   logic [3:0]         r_idx;
   logic [P_LENW-1:0]  r_len;
   logic               r_pad_done;
   logic               r_len_done;
   logic               r_final;
   logic               r_msg_end;
   logic [15:0][63:0]  r_buf;      // word 0 sits in the top slice
   logic [511:0]       r_chain;
   logic [511:0]       r_hash;

   logic [3:0]         w_n;
   logic [3:0]         w_widx;
   logic [6:0]         w_len_add;
   logic [63:0]        w_last_word;
   logic [127:0]       w_len128;
   logic [63:0]        w_pad_word;
   logic               w_pad_set_pad;
   logic               w_pad_set_len;
   logic               w_pad_set_final;

   assign w_n       = (i_nbytes > 4'd8) ? 4'd8 : i_nbytes;
   assign w_widx    = 4'd15 - r_idx;
   assign w_len_add = i_last ? {w_n, 3'b000} : 7'd64;
   assign w_len128  = 128'(r_len);

   assign o_ready      = (r_state == S_FILL);
   assign o_core_start = (r_state == S_START);
   assign o_hash_valid = (r_state == S_OUT);
   assign o_core_data  = r_buf;
   assign o_core_vin   = r_chain;
   assign o_hash       = r_hash;

   // Final data word: keep the n valid bytes, drop in the 0x80 marker right after them, zero the rest.
   always_comb begin
      w_last_word = i_data;
      for (int b = 0; b < 8; b++) begin
         if (4'(b) == w_n)
            w_last_word[63-8*b -: 8] = 8'h80;
         else if (4'(b) > w_n)
            w_last_word[63-8*b -: 8] = 8'h00;
      end
   end

   // Padding word chooser: marker first, then the two length halves at 14/15, zeros elsewhere.
   always_comb begin
      w_pad_word      = 64'h0;
      w_pad_set_pad   = 1'b0;
      w_pad_set_len   = 1'b0;
      w_pad_set_final = 1'b0;
      if (!r_pad_done) begin
         w_pad_word    = 64'h8000_0000_0000_0000;
         w_pad_set_pad = 1'b1;
      end else if (r_idx == 4'd14) begin
         w_pad_word    = w_len128[127:64];
         w_pad_set_len = 1'b1;
      end else if (r_idx == 4'd15 && r_len_done) begin
         w_pad_word      = w_len128[63:0];
         w_pad_set_final = 1'b1;
      end
   end

   // Block assembly, length tracking, core sequencing and digest capture.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_FILL;
         r_idx      <= 4'd0;
         r_len      <= '0;
         r_pad_done <= 1'b0;
         r_len_done <= 1'b0;
         r_final    <= 1'b0;
         r_msg_end  <= 1'b0;
         r_buf      <= '0;
         r_chain    <= P_IV;
         r_hash     <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (i_valid) begin
                  r_idx <= r_idx + 4'd1;
                  r_len <= r_len + P_LENW'(w_len_add);
                  if (!i_last) begin
                     r_buf[w_widx] <= i_data;
                     if (r_idx == 4'd15)
                        r_state <= S_START;
                  end else begin
                     r_buf[w_widx] <= w_last_word;
                     r_msg_end     <= 1'b1;
                     if (w_n != 4'd8)
                        r_pad_done <= 1'b1;
                     r_state <= (r_idx == 4'd15) ? S_START : S_PAD;
                  end
               end
            end
            S_PAD: begin
               r_buf[w_widx] <= w_pad_word;
               r_idx         <= r_idx + 4'd1;
               if (w_pad_set_pad)
                  r_pad_done <= 1'b1;
               if (w_pad_set_len)
                  r_len_done <= 1'b1;
               if (w_pad_set_final)
                  r_final <= 1'b1;
               if (r_idx == 4'd15)
                  r_state <= S_START;
            end
            S_START: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Block and chaining value stay frozen until the core reports back.
               if (i_core_done) begin
                  r_chain <= i_core_vout;
                  r_idx   <= 4'd0;
                  r_buf   <= '0;
                  if (r_final) begin
                     r_hash  <= i_core_vout;
                     r_state <= S_OUT;
                  end else if (r_msg_end) begin
                     r_state <= S_PAD;
                  end else begin
                     r_state <= S_FILL;
                  end
               end
            end
            S_OUT: begin
               r_len      <= '0;
               r_pad_done <= 1'b0;
               r_len_done <= 1'b0;
               r_final    <= 1'b0;
               r_msg_end  <= 1'b0;
               r_chain    <= P_IV;
               r_state    <= S_FILL;
            end
            default: begin
               r_state <= S_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha512_msg_pad.sv
// Bench for sha512_msg_pad: byte-level FIPS 180-4 padding model feeds a block/digest scoreboard.
// A stub core answers each start after a programmable delay with a simple mix of the presented block and chain.
// Scenario tasks check reset values, block counts, start latency and reset-abandon behaviour.
module tb_sha512_msg_pad;

   localparam logic [511:0] IV = 512'h6a09e667f3bcc908_bb67ae8584caa73b_3c6ef372fe94f82b_a54ff53a5f1d36f1_510e527fade682d1_9b05688c2b3e6c1f_1f83d9abfb41bd6b_5be0cd19137e2179;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [63:0]   i_data = '0;
   logic          i_valid = 1'b0;
   logic          i_last = 1'b0;
   logic [3:0]    i_nbytes = '0;
   logic          o_ready;
   logic          o_core_start;
   logic [1023:0] o_core_data;
   logic [511:0]  o_core_vin;
   logic [511:0]  i_core_vout = '0;
   logic          i_core_done = 1'b0;
   logic [511:0]  o_hash;
   logic          o_hash_valid;

   sha512_msg_pad dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .i_last       (i_last),
      .i_nbytes     (i_nbytes),
      .o_ready      (o_ready),
      .o_core_start (o_core_start),
      .o_core_data  (o_core_data),
      .o_core_vin   (o_core_vin),
      .i_core_vout  (i_core_vout),
      .i_core_done  (i_core_done),
      .o_hash       (o_hash),
      .o_hash_valid (o_hash_valid)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int n_starts = 0;
   int core_delay = 3;
   int start_cycs[$];
   logic [7:0]    msg_q[$];
   logic [1023:0] exp_dat[$];
   logic [511:0]  exp_vin[$];
   logic [511:0]  exp_hash[$];

   always @(posedge i_clk) cyc++;

   // Stand-in compression function shared by the stub core and the reference model.
   function automatic logic [511:0] mix(input logic [511:0] v, input logic [1023:0] d);
      return {v[447:0], v[511:448]} ^ d[1023:512] ^ {d[510:0], d[511]};
   endfunction

   // Stub core: answers each start after core_delay cycles using what the feeder is presenting at that time.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_core_start && !i_rst) begin
            repeat (core_delay) @(posedge i_clk);
            #1;
            i_core_vout = mix(o_core_vin, o_core_data);
            i_core_done = 1'b1;
            @(posedge i_clk);
            #1;
            i_core_done = 1'b0;
         end
      end
   end

   // Scoreboard: compare every presented block and every digest against the model queues.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_core_start) begin
            n_starts++;
            start_cycs.push_back(cyc);
            checks++;
            if (exp_dat.size() == 0) begin
               errors++;
               $display("FAIL unexpected_start at cycle %0d", cyc);
            end else begin
               logic [1023:0] ed;
               logic [511:0]  ev;
               ed = exp_dat.pop_front();
               ev = exp_vin.pop_front();
               if (o_core_data !== ed) begin
                  errors++;
                  $display("FAIL blk_data got %h", o_core_data);
                  $display("FAIL blk_data exp %h", ed);
               end
               checks++;
               if (o_core_vin !== ev) begin
                  errors++;
                  $display("FAIL blk_vin got %h exp %h", o_core_vin, ev);
               end
            end
         end
         if (o_hash_valid) begin
            checks++;
            if (exp_hash.size() == 0) begin
               errors++;
               $display("FAIL unexpected_hash_valid at cycle %0d", cyc);
            end else begin
               logic [511:0] eh;
               eh = exp_hash.pop_front();
               if (o_hash !== eh) begin
                  errors++;
                  $display("FAIL digest got %h exp %h", o_hash, eh);
               end
            end
         end
      end
   end

   // Reference: pad msg_q byte-wise per FIPS 180-4, split into blocks, chain through mix.
   task automatic model_push();
      logic [7:0]    p[$];
      logic [127:0]  lbits;
      logic [1023:0] blk;
      logic [511:0]  ch;
      int            nblk;
      p = msg_q;
      lbits = 128'(msg_q.size()) * 128'd8;
      p.push_back(8'h80);
      while ((p.size() % 128) != 112) p.push_back(8'h00);
      for (int i = 0; i < 16; i++) p.push_back(lbits[127-8*i -: 8]);
      nblk = p.size() / 128;
      ch = IV;
      for (int k = 0; k < nblk; k++) begin
         for (int i = 0; i < 128; i++) blk[1023-8*i -: 8] = p[k*128+i];
         exp_dat.push_back(blk);
         exp_vin.push_back(ch);
         ch = mix(ch, blk);
      end
      exp_hash.push_back(ch);
   endtask

   // One word with handshake; expects to be entered just after a rising edge.
   task automatic drive_word(input logic [63:0] d, input logic lst, input logic [3:0] nb);
      bit acc;
      int t;
      acc = 1'b0;
      t = 0;
      i_data = d;
      i_valid = 1'b1;
      i_last = lst;
      i_nbytes = nb;
      while (!acc && t < 3000) begin
         @(negedge i_clk);
         acc = o_ready;
         if (acc) hs_cyc = cyc;
         @(posedge i_clk);
         #1;
         t++;
      end
      i_valid = 1'b0;
      i_last = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL handshake_timeout got ready=%0b exp 1", o_ready);
      end
   endtask

   // mode 0: plain; mode 1: full last word followed by an empty last word; mode 2: full last word with nbytes=15.
   task automatic send_msg(input int mode);
      int L, nw, n;
      logic [63:0] w;
      logic lst;
      logic [3:0] nb;
      L = msg_q.size();
      model_push();
      @(posedge i_clk);
      #1;
      if (L == 0) begin
         drive_word(64'h0123_4567_89ab_cdef, 1'b1, 4'd0);
      end else begin
         nw = (L + 7) / 8;
         for (int wi = 0; wi < nw; wi++) begin
            n = (wi == nw - 1) ? (L - 8 * wi) : 8;
            for (int b = 0; b < 8; b++)
               w[63-8*b -: 8] = (b < n) ? msg_q[8*wi+b] : 8'hA5;
            lst = (wi == nw - 1) && !(mode == 1 && n == 8);
            nb = (mode == 2 && n == 8) ? 4'd15 : 4'(n);
            drive_word(w, lst, lst ? nb : 4'd5);
         end
         if (mode == 1 && (L % 8) == 0)
            drive_word(64'hdead_beef_cafe_f00d, 1'b1, 4'd0);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_hash.size() != 0 || exp_dat.size() != 0) && t < 3000) begin
         @(negedge i_clk);
         t++;
      end
      checks++;
      if (exp_hash.size() != 0 || exp_dat.size() != 0) begin
         errors++;
         $display("FAIL completion_timeout got pending blk=%0d hash=%0d exp 0", exp_dat.size(), exp_hash.size());
      end
   endtask

   task automatic fill_msg(input int len, input int seed);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'((i * 7 + seed) & 8'hff));
   endtask

   task automatic run_msg(input int mode);
      n_starts = 0;
      start_cycs.delete();
      send_msg(mode);
      wait_idle();
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      checks++; if (o_ready !== 1'b1)        begin errors++; $display("FAIL rst_ready got %b exp 1", o_ready); end
      checks++; if (o_core_start !== 1'b0)   begin errors++; $display("FAIL rst_start got %b exp 0", o_core_start); end
      checks++; if (o_hash_valid !== 1'b0)   begin errors++; $display("FAIL rst_hash_valid got %b exp 0", o_hash_valid); end
      checks++; if (o_hash !== 512'h0)       begin errors++; $display("FAIL rst_hash got %h exp 0", o_hash); end
      checks++; if (o_core_vin !== IV)       begin errors++; $display("FAIL rst_vin got %h exp %h", o_core_vin, IV); end
      checks++; if (o_core_data !== 1024'h0) begin errors++; $display("FAIL rst_data got %h exp 0", o_core_data); end
   endtask

   task automatic test_empty();
      msg_q.delete();
      run_msg(0);
      checks++; if (n_starts != 1) begin errors++; $display("FAIL empty_starts got %0d exp 1", n_starts); end
   endtask

   task automatic test_abc();
      msg_q.delete();
      msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
      run_msg(0);
      checks++; if (n_starts != 1) begin errors++; $display("FAIL abc_starts got %0d exp 1", n_starts); end
      checks++;
      if (start_cycs.size() == 0 || start_cycs[0] - hs_cyc != 16) begin
         errors++;
         $display("FAIL abc_latency got %0d exp 16", (start_cycs.size() == 0) ? -1 : start_cycs[0] - hs_cyc);
      end
   endtask

   task automatic test_111();
      fill_msg(111, 3);
      run_msg(0);
      checks++; if (n_starts != 1) begin errors++; $display("FAIL b111_starts got %0d exp 1", n_starts); end
      checks++;
      if (start_cycs.size() == 0 || start_cycs[0] - hs_cyc != 3) begin
         errors++;
         $display("FAIL b111_latency got %0d exp 3", (start_cycs.size() == 0) ? -1 : start_cycs[0] - hs_cyc);
      end
   endtask

   task automatic test_112();
      fill_msg(112, 11);
      run_msg(0);
      checks++; if (n_starts != 2) begin errors++; $display("FAIL b112_starts got %0d exp 2", n_starts); end
   endtask

   task automatic test_128();
      fill_msg(128, 29);
      run_msg(0);
      checks++; if (n_starts != 2) begin errors++; $display("FAIL b128_starts got %0d exp 2", n_starts); end
   endtask

   task automatic test_back_to_back();
      int lens[6] = '{8, 104, 120, 127, 200, 13};
      int mods[6] = '{1, 2, 0, 0, 0, 0};
      int blks[6] = '{1, 1, 2, 2, 2, 1};
      for (int k = 0; k < 6; k++) begin
         core_delay = 2 + k;
         if (k == 4) begin
            msg_q.delete();
            for (int i = 0; i < lens[k]; i++) msg_q.push_back(8'($urandom_range(0, 255)));
         end else begin
            fill_msg(lens[k], 40 + k);
         end
         run_msg(mods[k]);
         checks++;
         if (n_starts != blks[k]) begin
            errors++;
            $display("FAIL b2b_starts len=%0d got %0d exp %0d", lens[k], n_starts, blks[k]);
         end
      end
      core_delay = 3;
   endtask

   task automatic test_reset_wait();
      int t;
      core_delay = 30;
      n_starts = 0;
      msg_q.delete();
      msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
      send_msg(0);
      t = 0;
      while (exp_dat.size() != 0 && t < 200) begin @(negedge i_clk); t++; end
      checks++; if (n_starts != 1) begin errors++; $display("FAIL rw_first_start got %0d exp 1", n_starts); end
      repeat (4) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      exp_hash.delete();
      exp_dat.delete();
      exp_vin.delete();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      checks++; if (o_ready !== 1'b1)  begin errors++; $display("FAIL rw_ready got %b exp 1", o_ready); end
      checks++; if (o_core_vin !== IV) begin errors++; $display("FAIL rw_vin got %h exp %h", o_core_vin, IV); end
      // Let the stale done from the abandoned block arrive while idle.
      repeat (40) @(negedge i_clk);
      checks++; if (o_ready !== 1'b1)  begin errors++; $display("FAIL rw_stale_done got ready=%b exp 1", o_ready); end
      checks++; if (o_core_vin !== IV) begin errors++; $display("FAIL rw_stale_vin got %h exp %h", o_core_vin, IV); end
      core_delay = 3;
      run_msg(0);
      checks++; if (n_starts != 1) begin errors++; $display("FAIL rw_abc_starts got %0d exp 1", n_starts); end
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      test_reset();
      test_empty();
      test_abc();
      test_111();
      test_112();
      test_128();
      test_back_to_back();
      test_reset_wait();
      repeat (5) @(posedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
